tia_lfsr_counter: RTL

- Parametrised, single-clock successor to the two-phase TIA horizontal LFSR counter.
- Holds a WIDTH-bit XNOR-feedback shift register and advances it on a qualifying enable.
- Wraps to zero at a programmable terminal state, supports synchronous clear and parallel load, and escapes the XNOR lock-up state.
- Provides NUM_DECODE run-time-programmable state decoders.
- Feeds horizontal timing (sync/blank/object position) and object position counters.

---
 rtl/tia_lfsr_counter_pkg.sv | 36 +++
 rtl/tia_lfsr_step.sv | 25 ++
 rtl/tia_lfsr_counter.sv | 70 +++++++
 3 files changed

// File: rtl/tia_lfsr_counter_pkg.sv
// Shared horizontal-counter constants, control decode and the default parameter values.
// The guarded macro block mirrors the legacy tia_defines.v header so older files keep compiling.
`ifndef TIA_DEFINES_V
`define TIA_DEFINES_V
`define TIA_HCOUNT_WIDTH 6
`define TIA_HCOUNT_TAPS  6'b000011
`define TIA_HCOUNT_WRAP  6'b010100
`define TIA_OBJ_NUM_DECODE 4
`endif

package tia_lfsr_counter_pkg;

  localparam int unsigned TIA_WIDTH_DEF = `TIA_HCOUNT_WIDTH;
  localparam logic [TIA_WIDTH_DEF-1:0] TIA_TAPS_DEF = `TIA_HCOUNT_TAPS;
  localparam logic [TIA_WIDTH_DEF-1:0] TIA_WRAP_DEF = `TIA_HCOUNT_WRAP;
  localparam int unsigned TIA_NUM_DECODE_DEF = `TIA_OBJ_NUM_DECODE;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'd0,
    OP_CLEAR   = 2'd1,
    OP_LOAD    = 2'd2,
    OP_ADVANCE = 2'd3
  } tia_op_e;

  // Clear beats load beats advance; reset is handled separately by the register.
  function automatic tia_op_e tia_sel_op(input logic clear, input logic load,
                                         input logic advance);
    tia_op_e op;
    op = OP_HOLD;
    if (clear)        op = OP_CLEAR;
    else if (load)    op = OP_LOAD;
    else if (advance) op = OP_ADVANCE;
    return op;
  endfunction

endpackage

// File: rtl/tia_lfsr_step.sv
// Combinational successor of an XNOR LFSR state, including the terminal-state wrap
// and the all-ones lock-up escape.
module tia_lfsr_step
  import tia_lfsr_counter_pkg::*;
#(
  parameter int unsigned WIDTH = TIA_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAP_MASK = TIA_TAPS_DEF,
  parameter logic [WIDTH-1:0] WRAP_STATE = TIA_WRAP_DEF
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state,
  output logic             at_wrap
);

  logic feedback;

  always_comb begin
    feedback = ~^(state & TAP_MASK);
    at_wrap  = (state == WRAP_STATE);
    // All-ones is a fixed point of XNOR feedback, so it is forced to zero like a wrap.
    if (at_wrap || (&state)) next_state = '0;
    else                     next_state = {feedback, state[WIDTH-1:1]};
  end

endmodule

// File: rtl/tia_lfsr_counter.sv
// Single-clock horizontal LFSR counter with clear, parallel load, terminal wrap pulse
// and run-time programmable state decoders.
module tia_lfsr_counter
  import tia_lfsr_counter_pkg::*;
#(
  parameter int unsigned WIDTH = TIA_WIDTH_DEF,
  parameter logic [WIDTH-1:0] TAP_MASK = TIA_TAPS_DEF,
  parameter logic [WIDTH-1:0] WRAP_STATE = TIA_WRAP_DEF,
  parameter int unsigned NUM_DECODE = TIA_NUM_DECODE_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clear,
  input  logic                          load,
  input  logic [WIDTH-1:0]              load_value,
  input  logic                          advance,
  input  logic [NUM_DECODE*WIDTH-1:0]   decode_values,
  output logic [WIDTH-1:0]              out,
  output logic                          wrap,
  output logic [NUM_DECODE-1:0]         decode_hit
);

  logic [WIDTH-1:0] next_state;
  logic             at_wrap;
  tia_op_e          op;

  assign op = tia_sel_op(clear, load, advance);

  tia_lfsr_step #(
    .WIDTH     (WIDTH),
    .TAP_MASK  (TAP_MASK),
    .WRAP_STATE(WRAP_STATE)
  ) u_step (
    .state     (out),
    .next_state(next_state),
    .at_wrap   (at_wrap)
  );

  // wrap is only raised by an advance out of the terminal state, never by a load of it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      case (op)
        OP_CLEAR: begin
          out  <= '0;
          wrap <= 1'b0;
        end
        OP_LOAD: begin
          out  <= load_value;
          wrap <= 1'b0;
        end
        OP_ADVANCE: begin
          out  <= next_state;
          wrap <= at_wrap;
        end
        default: begin
          out  <= out;
          wrap <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_DECODE; i++) begin : g_decode
    assign decode_hit[i] = (out == decode_values[i*WIDTH +: WIDTH]);
  end

endmodule
